// File: rtl/ram_stream_reader_pkg.sv
// Shared types for the RAM stream reader.
// Holds the control FSM state encoding.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry FIFO that absorbs RAM read data under backpressure.
// Ports: push/push_data in, pop in, count and head (oldest entry) out.
module ram_rd_skid #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ram_stream_reader.sv
// Fetches a run of words from a 1-cycle-latency RAM onto a valid/ready stream.
// Ports: start/start_addr/length cmd, busy/done status, RAM rd port, m_* stream.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter  int WIDTH_DATA = 16,
  parameter  int NUMWORDS   = 256,
  localparam int AW         = $clog2(NUMWORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         start_addr,
  input  logic [AW:0]           length,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [AW-1:0]         mem_rd_addr,
  input  logic [WIDTH_DATA-1:0] mem_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH_DATA-1:0] m_data,
  output logic                  m_last
);

  localparam logic [AW-1:0] LastAddr = AW'(NUMWORDS - 1);
  localparam logic [AW-1:0] AddrOne  = AW'(1);
  localparam logic [AW:0]   CntOne   = (AW + 1)'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   iss_q, iss_d;
  logic [AW:0]   pop_cnt_q, pop_cnt_d;
  logic          infl_q, infl_d;
  logic          infl_last_q, infl_last_d;

  logic [1:0]          fifo_count;
  logic [WIDTH_DATA:0] head;
  logic                pop;
  logic                issue;
  logic [2:0]          credit;

  ram_rd_skid #(
    .W(WIDTH_DATA + 1)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (infl_q),
    .push_data({infl_last_q, mem_rd_data}),
    .pop      (pop),
    .count    (fifo_count),
    .head     (head)
  );

  assign m_valid = (fifo_count != 2'd0);
  assign pop     = m_valid & m_ready;

  // Buffered plus in-flight words, less the one leaving now.
  assign credit = {1'b0, fifo_count} + {2'b0, infl_q} - {2'b0, pop};
  assign issue  = (state_q == READ) && (iss_q != len_q) && (credit < 3'd2);

  assign mem_rd_en   = issue;
  assign mem_rd_addr = issue ? addr_q : '0;
  assign m_data      = m_valid ? head[WIDTH_DATA-1:0] : '0;
  assign m_last      = m_valid & head[WIDTH_DATA];
  assign busy        = (state_q == READ) || (state_q == DRAIN);
  assign done        = (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    iss_d       = iss_q;
    pop_cnt_d   = pop_cnt_q;
    infl_d      = issue;
    infl_last_d = issue && ((iss_q + CntOne) == len_q);
    if (issue) begin
      iss_d  = iss_q + CntOne;
      // Explicit wrap so non-power-of-two depths never overrun.
      addr_d = (addr_q == LastAddr) ? '0 : addr_q + AddrOne;
    end
    if (pop) begin
      pop_cnt_d = pop_cnt_q + CntOne;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = start_addr;
          len_d     = length;
          iss_d     = '0;
          pop_cnt_d = '0;
          state_d   = (length == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue && ((iss_q + CntOne) == len_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && ((pop_cnt_q + CntOne) == len_q)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      iss_q       <= '0;
      pop_cnt_q   <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      iss_q       <= iss_d;
      pop_cnt_q   <= pop_cnt_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: 256-deep and 200-deep instances
// with behavioural RAMs and an expected-word scoreboard.
module tb_ram_stream_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;

  // Instance A: 256 words
  logic        a_start;
  logic [7:0]  a_sa;
  logic [8:0]  a_len;
  logic        a_busy, a_done, a_rd_en;
  logic [7:0]  a_rd_addr;
  logic [15:0] a_rd_data;
  logic        a_valid, a_ready, a_last;
  logic [15:0] a_data;
  logic [15:0] mem_a [256];

  // Instance B: 200 words
  logic        b_start;
  logic [7:0]  b_sa;
  logic [8:0]  b_len;
  logic        b_busy, b_done, b_rd_en;
  logic [7:0]  b_rd_addr;
  logic [15:0] b_rd_data;
  logic        b_valid, b_ready, b_last;
  logic [15:0] b_data;
  logic [15:0] mem_b [200];

  ram_stream_reader #(.WIDTH_DATA(16), .NUMWORDS(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .start_addr(a_sa),
    .length(a_len), .busy(a_busy), .done(a_done), .mem_rd_en(a_rd_en),
    .mem_rd_addr(a_rd_addr), .mem_rd_data(a_rd_data), .m_valid(a_valid),
    .m_ready(a_ready), .m_data(a_data), .m_last(a_last)
  );

  ram_stream_reader #(.WIDTH_DATA(16), .NUMWORDS(200)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .start_addr(b_sa),
    .length(b_len), .busy(b_busy), .done(b_done), .mem_rd_en(b_rd_en),
    .mem_rd_addr(b_rd_addr), .mem_rd_data(b_rd_data), .m_valid(b_valid),
    .m_ready(b_ready), .m_data(b_data), .m_last(b_last)
  );

  always @(posedge clk) if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
  always @(posedge clk) if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];

  logic [7:0]  qa_addr [$];
  logic [16:0] qa_word [$];
  logic [7:0]  qb_addr [$];
  logic [16:0] qb_word [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor A: addresses, words, stall stability, credit
  int          iss_a, pops_a, hs_a, last_hs_cyc;
  bit          prev_stall;
  logic [16:0] prev_word;

  initial begin
    hs_a = 0;
    last_hs_cyc = -10;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      iss_a = 0;
      pops_a = 0;
      prev_stall = 1'b0;
    end else begin
      if (a_busy) chk("a_credit", 32'((iss_a - pops_a) <= 2), 1);
      if (prev_stall) begin
        chk("a_hold_valid", 32'(a_valid), 1);
        chk("a_hold_word", 32'({a_last, a_data}), 32'(prev_word));
      end
      if (a_rd_en) begin
        chk("a_rd_in_busy", 32'(a_busy), 1);
        chk("a_rd_expected", 32'(qa_addr.size() > 0), 1);
        if (qa_addr.size() > 0)
          chk("a_rd_addr", 32'(a_rd_addr), 32'(qa_addr.pop_front()));
        iss_a++;
      end
      if (a_valid && a_ready) begin
        chk("a_word_expected", 32'(qa_word.size() > 0), 1);
        if (qa_word.size() > 0)
          chk("a_word", 32'({a_last, a_data}), 32'(qa_word.pop_front()));
        pops_a++;
        hs_a++;
        if (a_last) last_hs_cyc = cyc;
      end
      prev_stall = a_valid && !a_ready;
      prev_word  = {a_last, a_data};
    end
  end

  // Monitor B: addresses in range and in order, words in order
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_rd_en) begin
        chk("b_addr_range", 32'(b_rd_addr < 8'd200), 1);
        chk("b_rd_expected", 32'(qb_addr.size() > 0), 1);
        if (qb_addr.size() > 0)
          chk("b_rd_addr", 32'(b_rd_addr), 32'(qb_addr.pop_front()));
      end
      if (b_valid && b_ready) begin
        chk("b_word_expected", 32'(qb_word.size() > 0), 1);
        if (qb_word.size() > 0)
          chk("b_word", 32'({b_last, b_data}), 32'(qb_word.pop_front()));
      end
    end
  end

  int acc_cyc;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic kick_a(input logic [7:0] sa, input int len, input bit track);
    @(posedge clk);
    #1;
    a_start = 1'b1;
    a_sa    = sa;
    a_len   = 9'(len);
    if (track) begin
      for (int i = 0; i < len; i++) begin
        logic [7:0] ad;
        ad = 8'((int'(sa) + i) % 256);
        qa_addr.push_back(ad);
        qa_word.push_back({i == len - 1, 16'(3 * int'(ad))});
      end
    end
    @(posedge clk);
    #1;
    a_start = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done_a(input string tag, input int exp_cyc, input bit bp);
    bit seen = 1'b0;
    int k = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = a_done;
      if (!seen) begin
        @(posedge clk);
        #1;
        if (bp) a_ready = pat[k % 6];
        k++;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    if (seen) begin
      chk({tag, "_done_cyc"}, cyc, (exp_cyc < 0) ? last_hs_cyc + 1 : exp_cyc);
      chk({tag, "_busy_at_done"}, 32'(a_busy), 0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(a_done), 0);
    end
    a_ready = 1'b1;
    chk({tag, "_drained"}, qa_word.size() + qa_addr.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench timed out");
    $fatal(1, "timeout");
  end

  initial begin
    bit b_seen;
    int base;
    int n;
    for (int i = 0; i < 256; i++) mem_a[i] = 16'(3 * i);
    for (int i = 0; i < 200; i++) mem_b[i] = 16'(3 * i);
    rst_n = 1'b0;
    a_start = 1'b0; a_sa = '0; a_len = '0; a_ready = 1'b1;
    b_start = 1'b0; b_sa = '0; b_len = '0; b_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_rd_en", 32'(a_rd_en), 0);
    chk("rst_rd_addr", 32'(a_rd_addr), 0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_last", 32'(a_last), 0);
    chk("rst_data", 32'(a_data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic run: words 0x30,0x33,0x36,0x39 back-to-back
    kick_a(8'h10, 4, 1'b1);
    @(negedge clk);
    chk("basic_busy", 32'(a_busy), 1);
    chk("basic_lat0", 32'(a_valid), 0);
    @(negedge clk);
    chk("basic_lat1", 32'(a_valid), 0);
    @(negedge clk);
    chk("basic_lat2", 32'(a_valid), 1);
    chk("basic_first", 32'(a_data), 'h30);
    wait_done_a("basic", acc_cyc + 6, 1'b0);

    // Wrap across the top of a 256-word RAM
    kick_a(8'hFE, 4, 1'b1);
    wait_done_a("wrap256", -1, 1'b0);

    // Backpressure
    kick_a(8'h80, 8, 1'b1);
    wait_done_a("bp", -1, 1'b1);

    // Zero length
    kick_a(8'h33, 0, 1'b1);
    wait_done_a("len0", acc_cyc, 1'b0);

    // Second start while busy is ignored
    kick_a(8'h20, 5, 1'b1);
    @(posedge clk);
    #1;
    a_start = 1'b1;
    a_sa    = 8'h40;
    a_len   = 9'd3;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    wait_done_a("ignore", -1, 1'b0);
    repeat (4) @(negedge clk);
    chk("ignore_idle", 32'(a_busy), 0);

    // Reset after beat 3 of 8
    kick_a(8'h50, 8, 1'b1);
    base = hs_a;
    n = 0;
    while ((hs_a - base) < 3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_beats", 32'((hs_a - base) >= 3), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(a_busy), 0);
    chk("mid_done", 32'(a_done), 0);
    chk("mid_rd_en", 32'(a_rd_en), 0);
    chk("mid_rd_addr", 32'(a_rd_addr), 0);
    chk("mid_valid", 32'(a_valid), 0);
    chk("mid_last", 32'(a_last), 0);
    chk("mid_data", 32'(a_data), 0);
    qa_addr.delete();
    qa_word.delete();
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_done", 32'(a_done), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_no_done", 32'(a_done), 0);
    end

    // Fresh run after reset
    kick_a(8'h05, 2, 1'b1);
    wait_done_a("after_rst", -1, 1'b0);

    // Non-power-of-two wrap on the 200-word instance
    @(posedge clk);
    #1;
    b_start = 1'b1;
    b_sa    = 8'd198;
    b_len   = 9'd4;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ad;
      ad = 8'((198 + i) % 200);
      qb_addr.push_back(ad);
      qb_word.push_back({i == 3, 16'(3 * int'(ad))});
    end
    @(posedge clk);
    #1;
    b_start = 1'b0;
    b_seen = 1'b0;
    for (int k = 0; k < 60 && !b_seen; k++) begin
      @(negedge clk);
      b_seen = b_done;
    end
    chk("wrap200_done", 32'(b_seen), 1);
    chk("wrap200_drained", qb_addr.size() + qb_word.size(), 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
